fp_add_scheduler: RTL and testbench
===================================

Name: fp_add_scheduler

Overview:
- Shares one FP32 adder core (stb/ack operand handshake, stb/ack result handshake) among NUM_REQ requesters.
- Accepts operand pairs and arbitrates round-robin. Drives the core's operand handshake, retires the core's result, and returns each sum to the requester that issued it.
- Sits between coprocessor issue ports and the single adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- REQ_W, 2, requester index width; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 64, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operand pair valid
- req_a  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B; same packing as req_a
- req_ready  out  NUM_REQ  one-cycle accept pulse, one-hot
- resp_valid  out  NUM_REQ  result valid, one-hot to the issuing requester
- resp_ready  in  NUM_REQ  per-requester result accept
- resp_z  out  32  result word, shared by all requesters
- resp_err  out  1  result is a watchdog substitute (feature only; otherwise tied 0)
- add_a, add_b  out  32  operands to the adder core
- add_a_stb, add_b_stb  out  1  operand strobes
- add_a_ack, add_b_ack  in  1  operand acknowledges from the core
- add_z  in  32  core result
- add_z_stb  in  1  core result valid
- add_z_ack  out  1  core result acknowledge
- busy  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, immediate): all outputs 0, FSM to IDLE, round-robin pointer to NUM_REQ-1 so requester 0 has first priority.
- The adder core receives the same rst; this block does not drive the core's reset.
- IDLE:
  - If any req_valid is high, the arbiter grants the first requester searching upward (with wrap) from pointer+1.
  - req_ready[g] pulses for that cycle. req_a/req_b slices for g and the index g are latched. Pointer becomes g.
  - Next state is ISSUE. Requesters hold req_valid and operands until they see ready.
- ISSUE: add_a_stb and add_b_stb are high with the latched operands, and each strobe stays high until its own ack has been seen high. Per-operand "seen" flags are kept because the two acks may arrive on different cycles. When both have been seen, both strobes are low on the next cycle and the FSM moves to WAIT.
- WAIT: strobes low. When add_z_stb is high, add_z is latched, add_z_ack is driven high for exactly one cycle, and the FSM moves to DRAIN.
- DRAIN: add_z_ack low. Wait for add_z_stb low (the core has returned to its idle state), then move to RESP. This ordering guarantees the core never sees strobes while its result is still pending.
- RESP:
  - resp_valid[g] high and resp_z holds the latched sum until resp_ready[g] is high; this may stall indefinitely.
  - On the handshake cycle, resp_valid returns to 0 next cycle and the FSM goes to IDLE.
  - resp_ready on any other requester is ignored.
- Only one transaction is ever in flight. No new grant is made before RESP completes.
- Minimum latency from req_ready to resp_valid is core latency + 3 cycles.
- Simultaneous requests are served strictly round-robin.
- A requester that drops req_valid before being granted is simply skipped.
- Results are passed through bit-exact; no FP interpretation is done here.

Optional Feature:
- Macro FP_ADD_SCHED_WATCHDOG_EN.
- Defined:
  - A counter runs from entry into ISSUE. If add_z_stb is not seen within TIMEOUT_CYCLES, the FSM goes to RESP with resp_z = 32'h7FC00000 (canonical quiet NaN) and resp_err = 1.
  - Strobes are dropped. add_z_ack is pulsed once so a late core result is discarded.
  - resp_err is cleared when resp_valid drops.
- Undefined: no counter is built, resp_err is tied to 0, and WAIT blocks forever.

Decomposition:
- Package fp_sched_pkg holds:
  - FP32_W = 32
  - FP32_QNAN = 32'h7FC00000
  - FSM state encoding: IDLE, ISSUE, WAIT, DRAIN, RESP (3 bits)
- Sub-module rr_arbiter (parameter NUM_REQ): a combinational grant from a request vector plus the pointer, producing a one-hot grant, a grant index and an any-request flag. The pointer register lives in the parent.

Test Plan:
- Single request: req 0 with A=32'h3F800000 (1.0), B=32'h40000000 (2.0) -> one req_ready[0] pulse; resp_valid[0] with resp_z=32'h40400000 (3.0); add_z_ack high for exactly 1 cycle.
- All four requesters valid at once after reset -> grants in order 0,1,2,3. With requester 1 re-requesting during service of 2 -> order 0,1,2,3,1.
- Back-pressure: resp_ready[2] held low for 20 cycles -> resp_valid[2] and resp_z stable for those 20 cycles; no req_ready pulses and no core strobes meanwhile.
- Skewed acks: core model asserts add_a_ack 3 cycles before add_b_ack -> add_a_stb drops after its ack, add_b_stb held until its ack; exactly one operand capture by the core.
- Async reset asserted in WAIT -> all outputs 0 immediately, no resp_valid. After release, a new request on req 3 completes normally.
- Watchdog (macro defined, TIMEOUT_CYCLES=16): core stub never asserts add_z_stb -> 16 cycles after entering ISSUE, resp_valid[g]=1, resp_z=32'h7FC00000, resp_err=1.

Source files
------------

// File: rtl/fp_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_sched_pkg                                                         |
// | Shared widths, constants and FSM encoding for fp_add_scheduler.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package fp_sched_pkg;

  localparam int          FP32_W    = 32;
  localparam logic [31:0] FP32_QNAN = 32'h7FC00000;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter                                                           |
// | Combinational round-robin grant, searching upward from ptr+1.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int REQ_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [REQ_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [REQ_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [REQ_W-1:0] w_idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    w_idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = REQ_W'((int'(ptr) + k) % NUM_REQ);
      if (!any_req && req[w_idx]) begin
        any_req      = 1'b1;
        grant[w_idx] = 1'b1;
        grant_idx    = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_add_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fp_add_scheduler                                                     |
// | Shares one FP32 adder core among NUM_REQ requesters, one op at a     |
// | time. Optional watchdog: define FP_ADD_SCHED_WATCHDOG_EN.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fp_add_scheduler
  import fp_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int REQ_W          = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*32-1:0]    req_a,
  input  logic [NUM_REQ*32-1:0]    req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [FP32_W-1:0]        resp_z,
  output logic                     resp_err,
  output logic [FP32_W-1:0]        add_a,
  output logic [FP32_W-1:0]        add_b,
  output logic                     add_a_stb,
  output logic                     add_b_stb,
  input  logic                     add_a_ack,
  input  logic                     add_b_ack,
  input  logic [FP32_W-1:0]        add_z,
  input  logic                     add_z_stb,
  output logic                     add_z_ack,
  output logic                     busy
);

  logic [2:0]         r_state;
  logic [REQ_W-1:0]   r_ptr;
  logic [REQ_W-1:0]   r_gnt_idx;
  logic [FP32_W-1:0]  r_a;
  logic [FP32_W-1:0]  r_b;
  logic [FP32_W-1:0]  r_z;
  logic               r_a_seen;
  logic               r_b_seen;

  logic [NUM_REQ-1:0] w_grant;
  logic [REQ_W-1:0]   w_grant_idx;
  logic               w_any;
  logic               w_a_done;
  logic               w_b_done;
  logic               w_z_take;
  logic               w_resp_done;
  logic               w_timeout;
  logic               w_wd_ack;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .REQ_W   (REQ_W)
  ) u_arb (
    .req       (req_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any_req   (w_any)
  );

  // An operand counts as delivered once its ack coincides with its own strobe.
  assign w_a_done    = r_a_seen | (add_a_stb & add_a_ack);
  assign w_b_done    = r_b_seen | (add_b_stb & add_b_ack);
  assign w_z_take    = (r_state == S_WAIT) & add_z_stb;
  assign w_resp_done = (r_state == S_RESP) & resp_ready[r_gnt_idx];

`ifdef FP_ADD_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            r_wd_ack;
  logic            r_err;

  assign w_timeout = ((r_state == S_ISSUE) || (r_state == S_WAIT)) && !w_z_take &&
                     (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign w_wd_ack  = r_wd_ack;
  assign resp_err  = r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wd_cnt <= '0;
      r_wd_ack <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_wd_ack <= w_timeout;
      if ((r_state == S_ISSUE) || (r_state == S_WAIT))
        r_wd_cnt <= r_wd_cnt + 1'b1;
      else
        r_wd_cnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
      else if (w_resp_done)
        r_err <= 1'b0;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign w_wd_ack  = 1'b0;
  assign resp_err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ptr     <= REQ_W'(NUM_REQ - 1);
      r_gnt_idx <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_z       <= '0;
      r_a_seen  <= 1'b0;
      r_b_seen  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_a       <= req_a[{w_grant_idx, 5'd0} +: FP32_W];
            r_b       <= req_b[{w_grant_idx, 5'd0} +: FP32_W];
            r_gnt_idx <= w_grant_idx;
            r_ptr     <= w_grant_idx;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (w_timeout) begin
            r_z      <= FP32_QNAN;
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
            r_state  <= S_RESP;
          end else if (w_a_done && w_b_done) begin
            r_a_seen <= 1'b0;
            r_b_seen <= 1'b0;
            r_state  <= S_WAIT;
          end else begin
            r_a_seen <= w_a_done;
            r_b_seen <= w_b_done;
          end
        end
        S_WAIT: begin
          if (w_z_take) begin
            r_z     <= add_z;
            r_state <= S_DRAIN;
          end else if (w_timeout) begin
            r_z     <= FP32_QNAN;
            r_state <= S_RESP;
          end
        end
        // Hold off the response until the core has dropped its result strobe.
        S_DRAIN: begin
          if (!add_z_stb)
            r_state <= S_RESP;
        end
        S_RESP: begin
          if (w_resp_done)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready  = ((r_state == S_IDLE) && !rst) ? w_grant : '0;
  assign resp_valid = (r_state == S_RESP) ? (NUM_REQ'(1) << r_gnt_idx) : '0;
  assign resp_z     = r_z;
  assign add_a      = r_a;
  assign add_b      = r_b;
  assign add_a_stb  = (r_state == S_ISSUE) && !r_a_seen;
  assign add_b_stb  = (r_state == S_ISSUE) && !r_b_seen;
  assign add_z_ack  = w_z_take | w_wd_ack;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fp_add_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_fp_add_scheduler                                                  |
// | Directed bench with a behavioural adder core and response scoreboard.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_fp_add_scheduler;

  localparam int N = 4;

  // Hand-computed FP32 sums: 1+2, 2+2, 0.5+0.25, -1+1, 3+5, 10+6, 1.5+2.5
  localparam logic [31:0] VA [7] = '{32'h3F800000, 32'h40000000, 32'h3F000000, 32'hBF800000,
                                     32'h40400000, 32'h41200000, 32'h3FC00000};
  localparam logic [31:0] VB [7] = '{32'h40000000, 32'h40000000, 32'h3E800000, 32'h3F800000,
                                     32'h40A00000, 32'h40C00000, 32'h40200000};
  localparam logic [31:0] VZ [7] = '{32'h40400000, 32'h40800000, 32'h3F400000, 32'h00000000,
                                     32'h41000000, 32'h41800000, 32'h40800000};

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     resp_z, add_a, add_b, add_z;
  logic            resp_err, add_a_stb, add_b_stb, add_a_ack, add_b_ack;
  logic            add_z_stb, add_z_ack, busy;

  fp_add_scheduler #(.NUM_REQ(N), .REQ_W(2), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_z(resp_z), .resp_err(resp_err),
    .add_a(add_a), .add_b(add_b), .add_a_stb(add_a_stb), .add_b_stb(add_b_stb),
    .add_a_ack(add_a_ack), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] z;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  // ---------------- adder core model ----------------
  int          a_dly = 0, b_dly = 0, lat = 2;
  bit          never_resp = 1'b0;
  int          a_caps = 0, b_caps = 0, dbl_a = 0, dbl_b = 0;
  int          c_st, c_acnt, c_bcnt, c_lat;
  logic        c_got_a, c_got_b;
  logic [31:0] c_cap_a, c_cap_b;

  function automatic logic [31:0] core_sum(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 7; i++)
      if (VA[i] == a && VB[i] == b) return VZ[i];
    return 32'hDEADBEEF;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_ack <= 1'b0; add_b_ack <= 1'b0; add_z_stb <= 1'b0; add_z <= '0;
      c_st <= 0; c_acnt <= 0; c_bcnt <= 0; c_lat <= 0;
      c_got_a <= 1'b0; c_got_b <= 1'b0; c_cap_a <= '0; c_cap_b <= '0;
    end else begin
      if (add_a_stb && c_got_a) dbl_a <= dbl_a + 1;
      if (add_b_stb && c_got_b) dbl_b <= dbl_b + 1;
      case (c_st)
        0: begin
          if (add_a_stb && !c_got_a) begin
            if (add_a_ack) begin
              c_got_a <= 1'b1; c_cap_a <= add_a; add_a_ack <= 1'b0; a_caps <= a_caps + 1;
            end else if (c_acnt >= a_dly) add_a_ack <= 1'b1;
            else c_acnt <= c_acnt + 1;
          end
          if (add_b_stb && !c_got_b) begin
            if (add_b_ack) begin
              c_got_b <= 1'b1; c_cap_b <= add_b; add_b_ack <= 1'b0; b_caps <= b_caps + 1;
            end else if (c_bcnt >= b_dly) add_b_ack <= 1'b1;
            else c_bcnt <= c_bcnt + 1;
          end
          if (c_got_a && c_got_b) begin c_st <= 1; c_lat <= 0; end
        end
        1: if (!never_resp) begin
          if (c_lat >= lat) begin
            add_z <= core_sum(c_cap_a, c_cap_b); add_z_stb <= 1'b1; c_st <= 2;
          end else c_lat <= c_lat + 1;
        end
        2: if (add_z_ack) begin
          add_z_stb <= 1'b0; c_got_a <= 1'b0; c_got_b <= 1'b0;
          c_acnt <= 0; c_bcnt <= 0; c_st <= 0;
        end
        default: c_st <= 0;
      endcase
    end
  end

  // ---------------- requesters drop valid after acceptance ----------------
  initial begin
    logic [N-1:0] acc;
    forever begin
      @(negedge clk);
      if (|req_ready) begin
        acc = req_ready;
        @(posedge clk);
        #1 req_valid = req_valid & ~acc;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int          zack_cyc = 0, prev_a = 0, prev_b = 0;
  bit          stall_prev = 1'b0;
  logic [31:0] stall_z;
  logic [N-1:0] stall_v;

  function automatic int oh2idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (|req_ready) chk("req_ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (add_z_ack) zack_cyc++;
        if ((resp_valid & resp_ready) != '0) begin
          stall_prev = 1'b0;
          chk("resp_valid_onehot", 32'($onehot(resp_valid)), 32'd1);
          if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got idx %0d z %h, required no response", oh2idx(resp_valid), resp_z);
          end else begin
            e = sbq.pop_front();
            chk("resp_idx", 32'(oh2idx(resp_valid)), 32'(e.idx));
            chk("resp_z", resp_z, e.z);
            chk("resp_err", 32'(resp_err), 32'(e.err));
            chk("z_ack_cycles", 32'(zack_cyc), 32'd1);
            chk("a_captures", 32'(a_caps - prev_a), 32'd1);
            chk("b_captures", 32'(b_caps - prev_b), 32'd1);
          end
          zack_cyc = 0; prev_a = a_caps; prev_b = b_caps;
        end else if (|resp_valid) begin
          if (stall_prev) begin
            chk("stall_z_stable", resp_z, stall_z);
            chk("stall_valid_stable", 32'(resp_valid), 32'(stall_v));
          end
          chk("stall_quiet", 32'({req_ready, add_a_stb, add_b_stb}), 32'd0);
          stall_prev = 1'b1; stall_z = resp_z; stall_v = resp_valid;
        end else stall_prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input int r, input int v, input bit wd);
    exp_t e;
    req_a[r*32 +: 32] = VA[v];
    req_b[r*32 +: 32] = VB[v];
    req_valid[r] = 1'b1;
    e.idx = 2'(r);
    e.z   = wd ? 32'h7FC00000 : VZ[v];
    e.err = wd;
    sbq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sbq.size() != 0 || busy || req_valid != '0) && n < budget) begin
      @(posedge clk); n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sbq.size());
      sbq.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    req_valid = '0; req_a = '0; req_b = '0; resp_ready = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 32'({req_ready, resp_valid, resp_err, add_a_stb, add_b_stb, add_z_ack, busy}), 32'd0);
    chk("rst_resp_z", resp_z, 32'd0);
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // single request, 1.0 + 2.0
    issue(0, 0, 1'b0);
    wait_drain(200);

    // four simultaneous requests, then requester 1 again during service of 2
    do_reset();
    issue(0, 1, 1'b0); issue(1, 2, 1'b0); issue(2, 3, 1'b0); issue(3, 4, 1'b0);
    n = 0;
    while (!req_ready[2] && n < 200) begin @(negedge clk); n++; end
    chk("grant2_seen", 32'(req_ready[2]), 32'd1);
    @(posedge clk); #2;
    issue(1, 5, 1'b0);
    wait_drain(400);

    // back-pressure on requester 2 with requester 0 waiting
    resp_ready[2] = 1'b0;
    issue(2, 6, 1'b0);
    n = 0;
    while (!resp_valid[2] && n < 200) begin @(posedge clk); n++; end
    chk("bp_resp_seen", 32'(resp_valid[2]), 32'd1);
    #1 issue(0, 0, 1'b0);
    repeat (20) @(posedge clk);
    #1 chk("bp_still_valid", 32'(resp_valid), 32'b0100);
    resp_ready[2] = 1'b1;
    wait_drain(200);

    // skewed operand acks, both directions
    a_dly = 0; b_dly = 3;
    issue(1, 5, 1'b0);
    wait_drain(200);
    a_dly = 4; b_dly = 0;
    issue(3, 2, 1'b0);
    wait_drain(200);
    a_dly = 0; b_dly = 0;

    // async reset while waiting on the core
    lat = 10;
    issue(1, 1, 1'b0);
    n = 0;
    while (c_st != 1 && n < 200) begin @(posedge clk); n++; end
    chk("core_computing", 32'(c_st), 32'd1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("wait_rst_ctl", 32'({req_ready, resp_valid, resp_err, add_a_stb, add_b_stb, add_z_ack, busy}), 32'd0);
    chk("wait_rst_add_a", add_a, 32'd0);
    req_valid = '0;
    sbq.delete();
    @(negedge clk); rst = 1'b0;
    prev_a = a_caps; prev_b = b_caps; zack_cyc = 0; lat = 2;
    @(posedge clk); #1;
    issue(3, 4, 1'b0);
    wait_drain(200);

`ifdef FP_ADD_SCHED_WATCHDOG_EN
    do_reset();
    never_resp = 1'b1;
    issue(0, 0, 1'b1);
    n = 0;
    while (!req_ready[0] && n < 50) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (!resp_valid[0] && n < 50);
    chk("wd_latency", 32'(n), 32'd17);
    wait_drain(100);
    never_resp = 1'b0;
    do_reset();
`endif

    chk("a_double_capture", 32'(dbl_a), 32'd0);
    chk("b_double_capture", 32'(dbl_b), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
